// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store at a time against a byte-lane word RAM.
// Latency: rsp_valid rises LATENCY edges after acceptance, the acceptance edge being the first.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
//
// Ports: clk/reset_n (async active-low); req_valid/req_ready/req_write/req_addr/req_funct/
// req_wdata form the request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err form the
// response channel. rsp_rdata carries the extended load value, 0 for stores and errors.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              funct_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0]             mem [DEPTH_WORDS];

    logic                    accept;
    logic                    enter_resp;
    logic                    c_write;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [2:0]              c_funct;
    logic [31:0]             c_wdata;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [IDX_W-1:0]        ram_idx;
    logic [1:0]              off;
    logic                    oor;
    logic                    bad;
    logic                    acc_err;
    logic [3:0]              be;
    logic [31:0]             wlane;
    logic [31:0]             rd_word;
    logic [31:0]             rd_shift;
    logic [15:0]             half_sel;
    logic [31:0]             load_val;

    assign accept     = (state_q == S_IDLE) && req_valid;
    assign enter_resp = ((state_q == S_WAIT) && (cnt_q == 4'd1)) ||
                        (accept && (LATENCY == 1));

    // With LATENCY=1 the commit edge is the acceptance edge, so the live request
    // fields must be used instead of the (not yet loaded) capture registers.
    assign c_write = (state_q == S_IDLE) ? req_write : wr_q;
    assign c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign c_funct = (state_q == S_IDLE) ? req_funct : funct_q;
    assign c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

    assign word_idx = c_addr[ADDR_WIDTH-1:2];
    assign ram_idx  = word_idx[IDX_W-1:0];
    assign off      = c_addr[1:0];
    assign oor      = 32'(word_idx) >= DEPTH_U;
    assign rd_word  = mem[ram_idx];
    assign rd_shift = rd_word >> {off, 3'b000};
    assign half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

    // Access decode: byte enables, lane-replicated store data, alignment/funct errors.
    always_comb begin
        be       = 4'b0000;
        wlane    = 32'd0;
        bad      = 1'b0;
        load_val = 32'd0;
        case (c_funct)
            3'b000: begin
                be       = 4'b0001 << off;
                wlane    = {4{c_wdata[7:0]}};
                load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            3'b001: begin
                bad      = off[0];
                be       = off[1] ? 4'b1100 : 4'b0011;
                wlane    = {2{c_wdata[15:0]}};
                load_val = {{16{half_sel[15]}}, half_sel};
            end
            3'b010: begin
                bad      = |off;
                be       = 4'b1111;
                wlane    = c_wdata;
                load_val = rd_word;
            end
            3'b100: begin
                bad      = c_write;
                load_val = {24'd0, rd_shift[7:0]};
            end
            3'b101: begin
                bad      = c_write | off[0];
                load_val = {16'd0, half_sel};
            end
            default: bad = 1'b1;
        endcase
    end

    assign acc_err = bad | oor;
    assign err_d   = enter_resp ? acc_err : err_q;
    assign rdata_d = enter_resp ? ((c_write || acc_err) ? 32'd0 : load_val) : rdata_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (LATENCY > 1)) cnt_d = 4'(LATENCY - 1);
        else if (state_q == S_WAIT)  cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            funct_q <= 3'd0;
            wdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                funct_q <= req_funct;
                wdata_q <= req_wdata;
            end
        end
    end

    // RAM is never cleared; writes only land on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && c_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int AW    = 20;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_funct;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_funct (req_funct),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mmem [0:DEPTH-1];
    bit          m_pend, m_vld;
    logic [31:0] m_rd;
    logic        m_err;
    int          edge_n = 0;
    int          t_acc  = 0;
    logic        a_w;
    logic [AW-1:0] a_a;
    logic [2:0]  a_f;
    logic [31:0] a_d;

    task automatic model_access(input logic w, input logic [AW-1:0] a, input logic [2:0] f,
                                input logic [31:0] d, output logic [31:0] rd, output logic e);
        int idx, off, size;
        logic [31:0] mask, val;
        idx  = int'(a) / 4;
        off  = int'(a) % 4;
        size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : (f[1:0] == 2'd2) ? 4 : 0;
        e = (size == 0) || (f[2] && (w || size == 4)) || (idx >= DEPTH);
        if (!e) e = (off % size) != 0;
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                for (int b = 0; b < size; b++) mmem[idx][8*(off+b) +: 8] = d[8*b +: 8];
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
                val  = (mmem[idx] >> (8*off)) & mask;
                if (!f[2] && val[8*size-1]) val = val | ~mask;
                rd = val;
            end
        end
    endtask

    // Transaction timeline: accept, response visible after the LAT-th edge, retire on handshake.
    initial begin
        m_pend = 0; m_vld = 0; m_rd = 0; m_err = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_pend = 0; m_vld = 0; m_rd = 0; m_err = 0;
            end else begin
                edge_n++;
                if (m_vld) begin
                    if (rsp_ready) begin m_vld = 0; m_pend = 0; end
                end else if (!m_pend && req_valid) begin
                    m_pend = 1; t_acc = edge_n;
                    a_w = req_write; a_a = req_addr; a_f = req_funct; a_d = req_wdata;
                end
                if (m_pend && !m_vld && edge_n == t_acc + LAT - 1) begin
                    model_access(a_w, a_a, a_f, a_d, m_rd, m_err);
                    m_vld = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("cyc req_ready", {31'd0, req_ready}, {31'd0, !m_pend});
        chk("cyc rsp_valid", {31'd0, rsp_valid}, {31'd0, m_vld});
        if (m_vld || !reset_n) begin
            chk("cyc rsp_rdata", rsp_rdata, m_rd);
            chk("cyc rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic xact(input string nm, input logic w, input logic [AW-1:0] a, input logic [2:0] f,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                        input int hold);
        int n;
        bit seen;
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_funct = f; req_wdata = d;
        if (hold > 0) rsp_ready = 0;
        @(posedge clk);
        #1;
        // scramble inputs: the DUT must use what it captured
        req_valid = 0; req_write = ~w; req_addr = a ^ 20'h4; req_funct = f ^ 3'b001; req_wdata = ~d;
        n = 1; seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1; break; end
            @(posedge clk);
            n++;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s timeout: no rsp_valid within 20 cycles", nm);
            rsp_ready = 1;
            return;
        end
        chk({nm, " latency"}, 32'(n), 32'(LAT));
        chk({nm, " rdata"}, rsp_rdata, exp_d);
        chk({nm, " err"}, {31'd0, rsp_err}, {31'd0, exp_e});
        chk({nm, " model rdata"}, m_rd, exp_d);
        for (int k = 0; k < hold; k++) begin
            if (k == 2) begin
                req_valid = 1; req_write = 1; req_addr = a & ~20'h3; req_funct = 3'b010; req_wdata = 32'd0;
            end
            if (k == 3) req_valid = 0;
            @(posedge clk);
            @(negedge clk);
            chk({nm, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({nm, " hold rdata"}, rsp_rdata, exp_d);
            chk({nm, " hold err"}, {31'd0, rsp_err}, {31'd0, exp_e});
            chk({nm, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk({nm, " valid after hs"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_funct = 3'd0;
        req_wdata = 32'd0; rsp_ready = 1;
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;

        xact("SW 10",      1, 20'h00010, 3'b010, 32'hDEADBEEF, 32'h0,        0, 0);
        xact("LW 10",      0, 20'h00010, 3'b010, 32'h0,        32'hDEADBEEF, 0, 0);
        xact("SB 11",      1, 20'h00011, 3'b000, 32'h000000A5, 32'h0,        0, 0);
        xact("LW 10 sb",   0, 20'h00010, 3'b010, 32'h0,        32'hDEADA5EF, 0, 0);
        xact("LB 11",      0, 20'h00011, 3'b000, 32'h0,        32'hFFFFFFA5, 0, 0);
        xact("LBU 11",     0, 20'h00011, 3'b100, 32'h0,        32'h000000A5, 0, 0);
        xact("LHU 12",     0, 20'h00012, 3'b101, 32'h0,        32'h0000DEAD, 0, 0);
        xact("LH 12",      0, 20'h00012, 3'b001, 32'h0,        32'hFFFFDEAD, 0, 0);
        xact("LB 13",      0, 20'h00013, 3'b000, 32'h0,        32'hFFFFFFDE, 0, 0);
        xact("LBU 10",     0, 20'h00010, 3'b100, 32'h0,        32'h000000EF, 0, 0);
        xact("SW 12 mis",  1, 20'h00012, 3'b010, 32'h11111111, 32'h0,        1, 0);
        xact("LH 13 mis",  0, 20'h00013, 3'b001, 32'h0,        32'h0,        1, 0);
        xact("LW 10 keep", 0, 20'h00010, 3'b010, 32'h0,        32'hDEADA5EF, 0, 0);
        xact("LW oor",     0, 20'h01000, 3'b010, 32'h0,        32'h0,        1, 0);
        xact("LD f011",    0, 20'h00010, 3'b011, 32'h0,        32'h0,        1, 0);
        xact("SW 14",      1, 20'h00014, 3'b010, 32'h00000000, 32'h0,        0, 0);
        xact("SH 16",      1, 20'h00016, 3'b001, 32'hFFFF8001, 32'h0,        0, 0);
        xact("LW 14",      0, 20'h00014, 3'b010, 32'h0,        32'h80010000, 0, 0);
        xact("LH 16",      0, 20'h00016, 3'b001, 32'h0,        32'hFFFF8001, 0, 0);
        xact("LHU 14",     0, 20'h00014, 3'b101, 32'h0,        32'h00000000, 0, 0);
        xact("SW 20",      1, 20'h00020, 3'b010, 32'hCAFEF00D, 32'h0,        0, 0);
        xact("LW 10 bp",   0, 20'h00010, 3'b010, 32'h0,        32'hDEADA5EF, 0, 5);
        xact("LW 10 post", 0, 20'h00010, 3'b010, 32'h0,        32'hDEADA5EF, 0, 0);
        xact("ST f100",    1, 20'h00020, 3'b100, 32'h55555555, 32'h0,        1, 0);

        // reset while the store sits in WAIT
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 20'h00020; req_funct = 3'b010; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 0;
        reset_n = 0;
        #1;
        chk("rst-wait req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst-wait rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst-wait rsp_rdata", rsp_rdata, 32'd0);
        chk("rst-wait rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        xact("LW 20 after rst", 0, 20'h00020, 3'b010, 32'h0, 32'hCAFEF00D, 0, 0);

        chk("model word 10", mmem[4], 32'hDEADA5EF);
        chk("model word 14", mmem[5], 32'h80010000);
        chk("model word 20", mmem[8], 32'hCAFEF00D);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
